// File: rtl/fp_dmux_scan_pkg.sv
// rtl/fp_dmux_scan_pkg.sv - shared defaults, channel indices and select-mode type for the front-panel mux
package fp_dmux_scan_pkg;

  localparam int DEF_WIDTH      = 12;
  localparam int DEF_N_CH       = 6;
  localparam int DEF_DEFAULT_CH = 5;
  localparam int DEF_SCAN_DIV   = 50_000_000;
  localparam int DEF_RUN_HOLD   = 5_000_000;

  localparam int CH_STATE  = 5;
  localparam int CH_STATUS = 4;
  localparam int CH_AC     = 3;
  localparam int CH_MB     = 2;
  localparam int CH_MQ     = 1;
  localparam int CH_BUS    = 0;

  typedef enum logic [1:0] {
    SEL_MANUAL,
    SEL_SCAN,
    SEL_DEFAULT
  } sel_mode_e;

endpackage

// File: rtl/fp_led_stretch.sv
// rtl/fp_led_stretch.sv - RUN lamp pulse stretcher
// Keeps the lamp lit RUN_HOLD clocks after running drops so short bursts stay visible.
module fp_led_stretch
  import fp_dmux_scan_pkg::*;
#(
  parameter int RUN_HOLD = DEF_RUN_HOLD
) (
  input  logic clk,
  input  logic reset,
  input  logic running,
  input  logic sw_active,
  output logic run_led
);

  localparam int HW = (RUN_HOLD > 0) ? $clog2(RUN_HOLD + 1) : 1;

  logic [HW-1:0] hold_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (running) begin
      hold_cnt <= HW'(RUN_HOLD);
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - 1'b1;
    end
  end

  assign run_led = running | (hold_cnt != '0) | sw_active;

endmodule

// File: rtl/fp_dmux_scan.sv
// rtl/fp_dmux_scan.sv - front-panel data mux with priority select, timed auto-scan and freeze
module fp_dmux_scan
  import fp_dmux_scan_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int N_CH       = DEF_N_CH,
  parameter int DEFAULT_CH = DEF_DEFAULT_CH,
  parameter int SCAN_DIV   = DEF_SCAN_DIV,
  parameter int RUN_HOLD   = DEF_RUN_HOLD
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH*WIDTH-1:0]   src,
  input  logic [N_CH-1:0]         dsel,
  input  logic                    scan_en,
  input  logic                    freeze,
  input  logic                    running,
  input  logic                    sw_active,
  output logic [WIDTH-1:0]        dout,
  output logic [$clog2(N_CH)-1:0] cur_ch,
  output logic                    run_led
);

  localparam int CW = $clog2(N_CH);
  localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  function automatic logic [CW-1:0] hi_index(input logic [N_CH-1:0] v);
    hi_index = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (v[i]) hi_index = CW'(i);
    end
  endfunction

  logic [WIDTH-1:0] src_arr [N_CH];
  logic [CW-1:0]    scan_idx;
  logic [TW-1:0]    scan_tmr;
  logic [CW-1:0]    manual_ch;
  logic [CW-1:0]    chosen;
  sel_mode_e        mode;

  for (genvar k = 0; k < N_CH; k++) begin : g_src
    assign src_arr[k] = src[k*WIDTH +: WIDTH];
  end

  always_comb begin
    manual_ch = hi_index(dsel);
    if (dsel != '0)   mode = SEL_MANUAL;
    else if (scan_en) mode = SEL_SCAN;
    else              mode = SEL_DEFAULT;
    case (mode)
      SEL_MANUAL: chosen = manual_ch;
      SEL_SCAN:   chosen = scan_idx;
      default:    chosen = CW'(DEFAULT_CH);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout     <= '0;
      cur_ch   <= CW'(DEFAULT_CH);
      scan_idx <= '0;
      scan_tmr <= '0;
    end else begin
      if (!freeze) begin
        dout   <= src_arr[chosen];
        cur_ch <= chosen;
      end
      // Manual viewing re-seeds the scan so it resumes here with a full dwell.
      case (mode)
        SEL_MANUAL: begin
          scan_tmr <= '0;
          scan_idx <= manual_ch;
        end
        SEL_SCAN: begin
          if (scan_tmr == TW'(SCAN_DIV - 1)) begin
            scan_tmr <= '0;
            scan_idx <= (scan_idx == CW'(N_CH - 1)) ? '0 : scan_idx + 1'b1;
          end else begin
            scan_tmr <= scan_tmr + 1'b1;
          end
        end
        default: scan_tmr <= '0;
      endcase
    end
  end

  fp_led_stretch #(
    .RUN_HOLD (RUN_HOLD)
  ) u_led_stretch (
    .clk       (clk),
    .reset     (reset),
    .running   (running),
    .sw_active (sw_active),
    .run_led   (run_led)
  );

endmodule
